// File: rtl/uart_boot_loader.sv
// Serial program loader: receives a framed image on rxd, writes it to memory
// from address 0 and holds the CPU in reset until the load has been ACKed.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_BYTES    = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        frame_error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);
    localparam logic [7:0] SYNC_B = 8'hA5;
    localparam logic [7:0] ACK_B  = 8'h06;
    localparam logic [7:0] NAK_B  = 8'h15;

    typedef enum logic [2:0] {
        S_WAIT_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_SEND_ACK,
        S_SEND_NAK,
        S_DONE
    } state_t;

    logic          r_rx_meta, r_rx_sync, r_rx_prev;
    logic          r_rx_busy;
    logic [3:0]    r_rx_bit;
    logic [CW-1:0] r_rx_cnt;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid, r_rx_bad;
    logic [CW-1:0] w_rx_lim;

    logic          r_tx_busy;
    logic [9:0]    r_tx_shift;
    logic [3:0]    r_tx_bit;
    logic [CW-1:0] r_tx_cnt;
    logic          w_tx_done, w_tx_start;
    logic [7:0]    w_tx_byte;

    state_t        r_state, w_next;
    logic [15:0]   r_len, w_len_nxt, w_len_rx;
    logic [15:0]   r_widx, w_widx_nxt, w_widx_inc;
    logic [1:0]    r_bidx, w_bidx_nxt;
    logic [31:0]   r_word, w_word_nxt;
    logic          r_ferr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Start bit waits half a bit so every later sample lands on a bit centre
    assign w_rx_lim = (r_rx_bit == 4'd0) ? HALF : FULL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_busy  <= 1'b0;
            r_rx_bit   <= 4'd0;
            r_rx_cnt   <= '0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_bad   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_bad   <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy <= 1'b1;
                    r_rx_bit  <= 4'd0;
                    r_rx_cnt  <= '0;
                end
            end else if (r_rx_cnt != w_rx_lim) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end else begin
                r_rx_cnt <= '0;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_sync) r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_sync) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                    end else begin
                        r_rx_bad <= 1'b1;
                    end
                end else begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                end
            end
        end
    end

    assign w_tx_done = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_busy  <= 1'b0;
            r_tx_shift <= 10'h3FF;
            r_tx_bit   <= 4'd0;
            r_tx_cnt   <= '0;
        end else if (w_tx_start) begin
            r_tx_busy  <= 1'b1;
            r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
            r_tx_bit   <= 4'd0;
            r_tx_cnt   <= '0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == FULL) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_bit   <= r_tx_bit + 4'd1;
                    r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign txd = r_tx_busy ? r_tx_shift[0] : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAIT_SYNC;
            r_len   <= 16'd0;
            r_widx  <= 16'd0;
            r_bidx  <= 2'd0;
            r_word  <= 32'd0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_len   <= w_len_nxt;
            r_widx  <= w_widx_nxt;
            r_bidx  <= w_bidx_nxt;
            r_word  <= w_word_nxt;
            if (r_rx_bad) r_ferr <= 1'b1;
        end
    end

    assign w_len_rx   = {r_rx_data, r_len[7:0]};
    assign w_widx_inc = r_widx + 16'd1;

    always_comb begin
        w_next     = r_state;
        w_len_nxt  = r_len;
        w_widx_nxt = r_widx;
        w_bidx_nxt = r_bidx;
        w_word_nxt = r_word;
        w_tx_start = 1'b0;
        w_tx_byte  = ACK_B;
        unique case (r_state)
            S_WAIT_SYNC: begin
                if (r_rx_valid && r_rx_data == SYNC_B) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (r_rx_valid) begin
                    w_len_nxt[7:0] = r_rx_data;
                    w_next         = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (r_rx_valid) begin
                    w_len_nxt  = w_len_rx;
                    w_widx_nxt = 16'd0;
                    w_bidx_nxt = 2'd0;
                    if (w_len_rx == 16'd0) begin
                        w_next     = S_SEND_ACK;
                        w_tx_start = 1'b1;
                    end else if (w_len_rx > MAX_WORDS) begin
                        w_next     = S_SEND_NAK;
                        w_tx_start = 1'b1;
                        w_tx_byte  = NAK_B;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (r_rx_valid) begin
                    w_word_nxt[{r_bidx, 3'b000} +: 8] = r_rx_data;
                    w_bidx_nxt = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_widx_nxt = w_widx_inc;
                if (w_widx_inc == r_len) begin
                    w_next     = S_SEND_ACK;
                    w_tx_start = 1'b1;
                end else begin
                    w_next     = S_DATA;
                    w_bidx_nxt = 2'd0;
                    if (r_rx_valid) begin
                        w_word_nxt[7:0] = r_rx_data;
                        w_bidx_nxt      = 2'd1;
                    end
                end
            end
            S_SEND_ACK: begin
                if (w_tx_done) w_next = S_DONE;
            end
            S_SEND_NAK: begin
                if (w_tx_done) w_next = S_WAIT_SYNC;
            end
            S_DONE: begin
                w_next = S_DONE;
            end
            default: w_next = S_WAIT_SYNC;
        endcase
        // A bad stop bit aborts any load still being parsed
        if (r_rx_bad && r_state != S_SEND_ACK && r_state != S_SEND_NAK
            && r_state != S_DONE) begin
            w_next     = S_SEND_NAK;
            w_tx_start = 1'b1;
            w_tx_byte  = NAK_B;
        end
    end

    assign mem_write_en   = (r_state == S_WRITE);
    assign mem_address    = {14'd0, r_widx, 2'b00};
    assign mem_write_data = r_word;
    assign cpu_hold       = (r_state != S_DONE);
    assign load_done      = (r_state == S_DONE);
    assign frame_error    = r_ferr;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: drives framed images on rxd and scoreboards
// memory writes and the reply byte decoded from txd.
module tb_uart_boot_loader;

    localparam int CPB = 16;
    localparam int MB  = 800;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] wq[$];
    logic [7:0]  tq[$];
    logic [63:0] w_exp;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_BYTES   (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .txd           (txd),
        .mem_address   (mem_address),
        .mem_write_en  (mem_write_en),
        .mem_write_data(mem_write_data),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .frame_error   (frame_error)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write scoreboard
    always @(negedge clk) begin
        if (reset && mem_write_en) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", mem_address, 32'hFFFF_FFFF);
            end else begin
                w_exp = wq.pop_front();
                check("wr_addr", mem_address, w_exp[63:32]);
                check("wr_data", mem_write_data, w_exp[31:0]);
            end
        end
    end

    // TX decoder
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset && txd == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (txd == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (CPB) @(negedge clk);
                    check("tx_stop", {31'd0, txd}, 32'd1);
                    if (tq.size() == 0)
                        check("tx_unexpected", {24'd0, b}, 32'h100);
                    else
                        check("tx_byte", {24'd0, b}, {24'd0, tq.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_reset_vals();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_we", {31'd0, mem_write_en}, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_data", mem_write_data, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000; i++) begin
            if (tq.size() == 0) break;
            @(negedge clk);
        end
        check("tx_drain", tq.size(), 32'd0);
        repeat (CPB) @(negedge clk);
        check("wq_left", wq.size(), 32'd0);
    endtask

    task automatic check_status(input logic hold, input logic done,
                                input logic ferr);
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, hold});
        check("load_done", {31'd0, load_done}, {31'd0, done});
        check("frame_error", {31'd0, frame_error}, {31'd0, ferr});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Happy path
        wq.push_back({32'h0, 32'hDEADBEEF});
        wq.push_back({32'h4, 32'h12345678});
        tq.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_word(32'hDEADBEEF); send_word(32'h12345678);
        wait_drain();
        check_status(1'b0, 1'b1, 1'b0);

        // Leading junk
        do_reset();
        wq.push_back({32'h0, 32'h44332211});
        tq.push_back(8'h06);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'h44332211);
        wait_drain();
        check_status(1'b0, 1'b1, 1'b0);

        // Oversize N=201, then a valid load
        do_reset();
        tq.push_back(8'h15);
        send_byte(8'hA5); send_byte(8'hC9); send_byte(8'h00);
        wait_drain();
        check_status(1'b1, 1'b0, 1'b0);
        wq.push_back({32'h0, 32'hCAFEF00D});
        tq.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'hCAFEF00D);
        wait_drain();
        check_status(1'b0, 1'b1, 1'b0);

        // Framing error inside DATA, then recovery
        do_reset();
        tq.push_back(8'h15);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 1'b0);
        wait_drain();
        check_status(1'b1, 1'b0, 1'b1);
        wq.push_back({32'h0, 32'h0BADF00D});
        tq.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_word(32'h0BADF00D);
        wait_drain();
        check_status(1'b0, 1'b1, 1'b1);

        // Glitch between sync and length, then zero length
        do_reset();
        tq.push_back(8'h06);
        send_byte(8'hA5);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h00); send_byte(8'h00);
        wait_drain();
        check_status(1'b0, 1'b1, 1'b0);

        // Reset after two data bytes, then full reload
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        check("partial_word", mem_write_data, 32'h0000_2211);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        wq.push_back({32'h0, 32'h03020100});
        wq.push_back({32'h4, 32'hA1B2C3D4});
        tq.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_word(32'h03020100); send_word(32'hA1B2C3D4);
        wait_drain();
        check_status(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
